bitserial_exec: RTL and testbench
=================================

# bitserial_exec

Bit-serial execute unit that consumes the two-byte instruction assembled by the button-driven instruction loader. It drives the 8-bit LED result bus `out_result` on `uo_out`. Each instruction runs least-significant bit first over eight cycles through a 1-bit ALU and four 8-bit circular shift registers. The block sits directly downstream of the loader, inside the CPU core.

## Interface
- No parameters; data width fixed at 8, register count fixed at 4.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `opcode`  in  4  operation code from the loader; held stable between loads.
- `instr`  in  12  operand fields:
  - `[1:0]` rd
  - `[3:2]` rs
  - `[11:4]` imm8
- `inst_done`  in  1  loader phase flag; its 1->0 transition marks a complete instruction.
- `btn_edge`  in  1  synchronized button pulse; unused internally, tied off.
- `out_result`  out  8  LED result register.
- `busy`  out  1  high from the first EXEC cycle through the DONE cycle.
- `carry`  out  1  carry/no-borrow flag.

## Operation
- Start pulse: `start = done_q & ~inst_done`, where `done_q` is `inst_done` registered.
  - `done_q` resets to 0.
- On `start` in IDLE, latch `opcode` and `instr` into internal copies; later input changes have no effect on the running instruction.
- Register file: r0..r3, 8 bits each. Immediate shift register `imm_sr` is loaded from imm8.
- EXEC cycle, bit counter k = 0..7:
  - Every register and `imm_sr` rotates right one place.
  - A non-destination register shifts its old bit 0 back into bit 7, so it is unchanged after 8 cycles.
  - rd shifts the ALU result bit into bit 7 instead.
  - Operand bits are sampled before the shift. For rd == rs, both operands read the same bit.
- 1-bit ALU, a = rd[0], b = rs[0] or imm_sr[0], c = internal carry:
  - 0 NOP: rd gets a (rd unchanged).
  - 1 LDI: imm bit.
  - 2 ADD: a^b^c; c init 0.
  - 3 SUB: a^~b^c; c init 1.
  - 4 AND, 5 OR, 6 XOR: bitwise a,b.
  - 7 ADDI: a + imm bit; c init 0.
  - 8 NOT: ~b (rs).
  - 9 OUT: rd unchanged.
  - 10 MOV: b (rs).
  - 11–15: behave as NOP.
- Internal carry updates each bit: majority(a, b', c), where b' is the inverted b for SUB.
- `carry` output is written only at the end of ADD/SUB/ADDI, with the final carry out. SUB: 1 means no borrow. Other opcodes leave it unchanged.
- All arithmetic is modulo 256.
- DONE: if opcode is OUT, `out_result <= rd` (register already restored). All other opcodes leave `out_result` unchanged.
- FSM:
  - IDLE --start--> EXEC (k=0)
  - EXEC, k<7 --> EXEC (k+1)
  - EXEC, k=7 --> DONE
  - DONE --> IDLE

## Timing
- Reset values: `out_result` 0x00, `busy` 0, `carry` 0. r0..r3 all 0x00. State IDLE, k=0, `done_q` 0.
- Let edge E0 be the clock edge that samples `start`=1 in IDLE:
  - E0: operands latched, enter EXEC, `busy` rises after E0.
  - E1..E8: bits 0..7 processed; E8 enters DONE.
  - E9: `out_result`/`carry` written, return to IDLE, `busy` falls after E9.
- Latency is 9 cycles from the start edge to result visibility. Back-to-back starts are accepted from the cycle after E9 onward.
- `start` while `busy`: dropped, no queue, no effect on the running instruction or on the register file.
- `start` in the same cycle as DONE: dropped.
- `rst_n` low mid-EXEC/DONE:
  - Abort at the next edge; all state returns to reset values, including the register file.
  - No partial write is visible after reset.
- `inst_done` rising (first byte loaded) produces no start.
- `inst_done` held 0 produces exactly one start per 1->0 transition.

## Test plan
- Reset, then LDI r1,0x5A (opcode 1, instr 0x5A1), then OUT r1 (opcode 9, instr 0x001) -> `out_result`=0x5A exactly 9 cycles after the OUT start edge; `busy` high for 9 cycles each time.
- LDI r0,0xF0; LDI r1,0x20; ADD r0,r1 (instr 0x004); OUT r0 -> `out_result`=0x10, `carry`=1. Then OUT r1 -> 0x20, confirming the source is preserved.
- LDI r2,0x05; LDI r3,0x07; SUB r2,r3 (opcode 3, instr 0x00E); OUT r2 -> 0xFE, `carry`=0. Then SUB with r2=0x07, r3=0x05 -> 0x02, `carry`=1.
- LDI r0,0x81; ADD r0,r0 (instr 0x000) -> OUT 0x02, `carry`=1. ADDI r0,0xFF -> 0x01. NOT r1,r0 (instr 0x001) -> OUT r1 = 0xFE. Opcode 0xC -> no change.
- Second 1->0 `inst_done` transition issued 3 cycles into EXEC -> ignored; only the first instruction's result appears, and `busy` does not extend.
- `rst_n` low at E4 of ADD r0,r1 with r0=0x33 -> after reset, OUT of every register reads 0x00, `out_result`=0x00, `busy`=0, `carry`=0.

Source files
------------

// File: rtl/bitserial_exec.sv
// rtl/bitserial_exec.sv - bit-serial execute unit: 1-bit ALU over four 8-bit rotating registers
module bitserial_exec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic [11:0] instr,
  input  logic        inst_done,
  input  logic        btn_edge,
  output logic [7:0]  out_result,
  output logic        busy,
  output logic        carry
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_OUT  = 4'd9;
  localparam logic [3:0] OP_MOV  = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  bit_cnt;
  logic        done_q;
  logic        start;
  logic [3:0]  op_q;
  logic [1:0]  rd_q;
  logic [1:0]  rs_q;
  logic [7:0]  imm_sr;
  logic [7:0]  regs [4];
  logic        c_q;

  logic        a_bit;
  logic        rs_bit;
  logic        imm_bit;
  logic        b_bit;
  logic        b_eff;
  logic        res_bit;
  logic        c_nxt;

  // The button pulse is already consumed by the loader; nothing here needs it.
  logic unused_btn;
  assign unused_btn = btn_edge;

  // Register the loader phase flag so its falling edge can be detected.
  always_ff @(posedge clk) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= inst_done;
  end

  assign start = done_q & ~inst_done;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; busy covers every EXEC cycle and the DONE cycle.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_EXEC;
      S_EXEC: begin
        busy = 1'b1;
        if (bit_cnt == 3'd7) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // 1-bit ALU on the current LSBs; operands are sampled before the rotate.
  always_comb begin
    a_bit   = regs[rd_q][0];
    rs_bit  = regs[rs_q][0];
    imm_bit = imm_sr[0];
    b_bit   = (op_q == OP_ADDI) ? imm_bit : rs_bit;
    b_eff   = (op_q == OP_SUB) ? ~b_bit : b_bit;
    c_nxt   = (a_bit & b_eff) | (a_bit & c_q) | (b_eff & c_q);
    res_bit = a_bit;
    case (op_q)
      OP_NOP, OP_OUT:   res_bit = a_bit;
      OP_LDI:           res_bit = imm_bit;
      OP_ADD, OP_ADDI,
      OP_SUB:           res_bit = a_bit ^ b_eff ^ c_q;
      OP_AND:           res_bit = a_bit & rs_bit;
      OP_OR:            res_bit = a_bit | rs_bit;
      OP_XOR:           res_bit = a_bit ^ rs_bit;
      OP_NOT:           res_bit = ~rs_bit;
      OP_MOV:           res_bit = rs_bit;
      default:          res_bit = a_bit;
    endcase
  end

  // Datapath: latch the instruction, rotate all registers per bit, commit flags at DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt    <= 3'd0;
      op_q       <= 4'd0;
      rd_q       <= 2'd0;
      rs_q       <= 2'd0;
      imm_sr     <= 8'd0;
      c_q        <= 1'b0;
      out_result <= 8'd0;
      carry      <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= opcode;
            rd_q    <= instr[1:0];
            rs_q    <= instr[3:2];
            imm_sr  <= instr[11:4];
            bit_cnt <= 3'd0;
            // Subtraction is a + ~b + 1, so its carry chain starts at 1.
            c_q     <= (opcode == OP_SUB);
          end
        end
        S_EXEC: begin
          for (int i = 0; i < 4; i++) begin
            if (2'(i) == rd_q) regs[i] <= {res_bit, regs[i][7:1]};
            else               regs[i] <= {regs[i][0], regs[i][7:1]};
          end
          imm_sr  <= {imm_sr[0], imm_sr[7:1]};
          c_q     <= c_nxt;
          bit_cnt <= bit_cnt + 3'd1;
        end
        S_DONE: begin
          if (op_q == OP_OUT) out_result <= regs[rd_q];
          if (op_q == OP_ADD || op_q == OP_SUB || op_q == OP_ADDI) carry <= c_q;
        end
        default: bit_cnt <= 3'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_bitserial_exec.sv
// tb/tb_bitserial_exec.sv - self-checking bench for bitserial_exec
module tb_bitserial_exec;

  logic        clk;
  logic        rst_n;
  logic [3:0]  opcode;
  logic [11:0] instr;
  logic        inst_done;
  logic        btn_edge;
  logic [7:0]  out_result;
  logic        busy;
  logic        carry;

  typedef struct {
    logic [3:0]  op;
    logic [11:0] ins;
    logic [7:0]  exp_out;
    logic        exp_c;
  } vec_t;

  typedef struct {
    logic [7:0] o;
    logic       c;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   busy_cnt = 0;
  logic prev_busy = 1'b0;

  bitserial_exec dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .instr      (instr),
    .inst_done  (inst_done),
    .btn_edge   (btn_edge),
    .out_result (out_result),
    .busy       (busy),
    .carry      (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Completion monitor: each busy falling edge must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (prev_busy && !busy) begin
        check("busy_len", 8'(busy_cnt), 8'd9);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got 0x%0h, expected no completion", out_result);
        end else begin
          e = sb.pop_front();
          check("out_result", out_result, e.o);
          check("carry", {7'd0, carry}, {7'd0, e.c});
        end
        busy_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((sb.size() != 0 || busy) && n < 40);
    if (n >= 40) begin
      tests++;
      fails++;
      $display("FAIL completion_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Load one instruction via an inst_done 1->0 transition; optionally inject a second
  // transition 'inject' cycles later carrying a different instruction.
  task automatic issue(input logic [3:0] op, input logic [11:0] ins,
                       input logic [7:0] eo, input logic ec, input int inject);
    @(negedge clk);
    opcode    = op;
    instr     = ins;
    inst_done = 1'b1;
    @(negedge clk);
    inst_done = 1'b0;
    check("no_start_on_rise", {7'd0, busy}, 8'd0);
    sb.push_back('{eo, ec});
    if (inject > 0) begin
      repeat (inject) @(negedge clk);
      opcode    = 4'h1;
      instr     = 12'h771;
      inst_done = 1'b1;
      @(negedge clk);
      inst_done = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    opcode    = 4'h0;
    instr     = 12'h000;
    inst_done = 1'b0;
    btn_edge  = 1'b0;

    vecs.push_back('{4'h1, 12'h5A1, 8'h00, 1'b0}); // LDI r1,5A
    vecs.push_back('{4'h9, 12'h001, 8'h5A, 1'b0}); // OUT r1
    vecs.push_back('{4'h1, 12'hF00, 8'h5A, 1'b0}); // LDI r0,F0
    vecs.push_back('{4'h1, 12'h201, 8'h5A, 1'b0}); // LDI r1,20
    vecs.push_back('{4'h2, 12'h004, 8'h5A, 1'b1}); // ADD r0,r1
    vecs.push_back('{4'h9, 12'h000, 8'h10, 1'b1}); // OUT r0
    vecs.push_back('{4'h9, 12'h001, 8'h20, 1'b1}); // OUT r1
    vecs.push_back('{4'h1, 12'h052, 8'h20, 1'b1}); // LDI r2,05
    vecs.push_back('{4'h1, 12'h073, 8'h20, 1'b1}); // LDI r3,07
    vecs.push_back('{4'h3, 12'h00E, 8'h20, 1'b0}); // SUB r2,r3
    vecs.push_back('{4'h9, 12'h002, 8'hFE, 1'b0}); // OUT r2
    vecs.push_back('{4'h1, 12'h072, 8'hFE, 1'b0}); // LDI r2,07
    vecs.push_back('{4'h1, 12'h053, 8'hFE, 1'b0}); // LDI r3,05
    vecs.push_back('{4'h3, 12'h00E, 8'hFE, 1'b1}); // SUB r2,r3
    vecs.push_back('{4'h9, 12'h002, 8'h02, 1'b1}); // OUT r2
    vecs.push_back('{4'h1, 12'h810, 8'h02, 1'b1}); // LDI r0,81
    vecs.push_back('{4'h2, 12'h000, 8'h02, 1'b1}); // ADD r0,r0
    vecs.push_back('{4'h9, 12'h000, 8'h02, 1'b1}); // OUT r0
    vecs.push_back('{4'h7, 12'hFF0, 8'h02, 1'b1}); // ADDI r0,FF
    vecs.push_back('{4'h9, 12'h000, 8'h01, 1'b1}); // OUT r0
    vecs.push_back('{4'h8, 12'h001, 8'h01, 1'b1}); // NOT r1,r0
    vecs.push_back('{4'h9, 12'h001, 8'hFE, 1'b1}); // OUT r1
    vecs.push_back('{4'hC, 12'h001, 8'hFE, 1'b1}); // opcode C: no change
    vecs.push_back('{4'h9, 12'h001, 8'hFE, 1'b1}); // OUT r1
    vecs.push_back('{4'h5, 12'h004, 8'hFE, 1'b1}); // OR r0,r1
    vecs.push_back('{4'h9, 12'h000, 8'hFF, 1'b1}); // OUT r0
    vecs.push_back('{4'h4, 12'h004, 8'hFF, 1'b1}); // AND r0,r1
    vecs.push_back('{4'h9, 12'h000, 8'hFE, 1'b1}); // OUT r0
    vecs.push_back('{4'h6, 12'h004, 8'hFE, 1'b1}); // XOR r0,r1
    vecs.push_back('{4'h9, 12'h000, 8'h00, 1'b1}); // OUT r0
    vecs.push_back('{4'hA, 12'h007, 8'h00, 1'b1}); // MOV r3,r1
    vecs.push_back('{4'h9, 12'h003, 8'hFE, 1'b1}); // OUT r3
    vecs.push_back('{4'h2, 12'h000, 8'hFE, 1'b0}); // ADD r0,r0 (0+0)
    vecs.push_back('{4'h0, 12'hAB1, 8'hFE, 1'b0}); // NOP
    vecs.push_back('{4'h9, 12'h001, 8'hFE, 1'b0}); // OUT r1

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_out", out_result, 8'h00);
    check("reset_busy", {7'd0, busy}, 8'd0);
    check("reset_carry", {7'd0, carry}, 8'd0);

    foreach (vecs[i]) issue(vecs[i].op, vecs[i].ins, vecs[i].exp_out, vecs[i].exp_c, 0);

    // Second load during EXEC and during DONE must be dropped.
    issue(4'h1, 12'h331, 8'hFE, 1'b0, 3);  // LDI r1,33
    issue(4'h9, 12'h001, 8'h33, 1'b0, 8);  // OUT r1
    issue(4'h2, 12'h00D, 8'h33, 1'b1, 0);  // ADD r1,r3 -> 31, carry 1
    issue(4'h1, 12'h330, 8'h33, 1'b1, 0);  // LDI r0,33

    // ADD r0,r1 aborted by reset at E4.
    @(negedge clk);
    opcode    = 4'h2;
    instr     = 12'h004;
    inst_done = 1'b1;
    @(negedge clk);
    inst_done = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("abort_out", out_result, 8'h00);
    check("abort_busy", {7'd0, busy}, 8'd0);
    check("abort_carry", {7'd0, carry}, 8'd0);
    for (int r = 0; r < 4; r++) issue(4'h9, 12'(r), 8'h00, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
